axi_wr_subordinate: RTL and testbench



---
 rtl/axi_wr_subordinate.sv | 172 +++++++++++++++++
 tb/tb_axi_wr_subordinate.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_subordinate.sv
// AXI4 write-channel subordinate: one transaction at a time, FIXED/INCR/WRAP beat addressing,
// byte-enabled writes to a synchronous memory port and a single B response per burst.
module axi_wr_subordinate #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MEM_BYTES  = 4096,
    localparam int                   BUS_BYTES  = DATA_WIDTH / 8,
    localparam int                   IDX_W      = (MEM_BYTES > BUS_BYTES) ? $clog2(MEM_BYTES / BUS_BYTES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]            aw_len_i,
    input  logic [2:0]            aw_size_i,
    input  logic [1:0]            aw_burst_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [BUS_BYTES-1:0]  w_strb_i,
    input  logic                  w_last_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic                  mem_we_o,
    output logic [IDX_W-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BUS_BYTES-1:0]  mem_be_o
);
    localparam int OFF_W = $clog2(BUS_BYTES);
    localparam int EW    = ADDR_WIDTH + 17;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DATA, S_RESP} state_e;

    state_e                state_q, state_d;
    logic                  init_q;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [1:0]            err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    // Error decode of the AW request, done in a widened space so window ends cannot overflow
    logic [EW-1:0] ext_addr, win_lo, win_hi, aw_bsz, aw_aligned, aw_span, aw_lower, aw_last;
    logic          dec_err, slv_err;

    always_comb begin
        ext_addr   = EW'(aw_addr_i);
        win_lo     = EW'(BASE_ADDR);
        win_hi     = win_lo + EW'(MEM_BYTES);
        aw_bsz     = EW'(1) << aw_size_i;
        aw_aligned = ext_addr & ~(aw_bsz - EW'(1));
        aw_span    = (EW'(aw_len_i) + EW'(1)) << aw_size_i;
        aw_lower   = ext_addr & ~(aw_span - EW'(1));
        case (aw_burst_i)
            2'b00:   aw_last = aw_aligned + aw_bsz - EW'(1);
            2'b10:   aw_last = aw_lower + aw_span - EW'(1);
            default: aw_last = aw_aligned + aw_span - EW'(1);
        endcase
        dec_err = (ext_addr < win_lo) || (ext_addr >= win_hi) || (aw_last >= win_hi);
        slv_err = (aw_size_i > 3'(OFF_W)) || (aw_burst_i == 2'b11)
                || ((aw_burst_i == 2'b10) && !(aw_len_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
                || ((aw_burst_i == 2'b10) && ((ext_addr & (aw_bsz - EW'(1))) != '0))
                || ((aw_burst_i == 2'b01) && ((aw_aligned >> 12) != (aw_last >> 12)));
    end

    logic [ADDR_WIDTH-1:0] bsz_a, aligned_a, step_a, cont_a, lower_a, beat_addr;
    logic [7:0]            lane_lo, lane_hi;
    logic [BUS_BYTES-1:0]  lane_mask;
    logic                  final_beat;

    always_comb begin
        bsz_a     = ADDR_WIDTH'(1) << size_q;
        aligned_a = addr_q & ~(bsz_a - ADDR_WIDTH'(1));
        step_a    = ADDR_WIDTH'(cnt_q) << size_q;
        cont_a    = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
        lower_a   = addr_q & ~(cont_a - ADDR_WIDTH'(1));
        case (burst_q)
            2'b00:   beat_addr = addr_q;
            2'b10:   beat_addr = lower_a + ((addr_q - lower_a + step_a) & (cont_a - ADDR_WIDTH'(1)));
            default: beat_addr = (cnt_q == 8'd0) ? addr_q : aligned_a + step_a;
        endcase
        // First beat of an unaligned burst starts mid-lane; mask ends at the size boundary
        lane_lo   = 8'(beat_addr[OFF_W-1:0]);
        lane_hi   = lane_lo | 8'((9'd1 << size_q) - 9'd1);
        lane_mask = '0;
        for (int b = 0; b < BUS_BYTES; b++) begin
            lane_mask[b] = (8'(b) >= lane_lo) && (8'(b) <= lane_hi);
        end
    end

    assign final_beat = (cnt_q == len_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        case (state_q)
            S_INIT: if (init_q) state_d = S_IDLE;
            S_IDLE: begin
                if (aw_valid_i) begin
                    id_d    = aw_id_i;
                    addr_d  = aw_addr_i;
                    len_d   = aw_len_i;
                    size_d  = aw_size_i;
                    burst_d = aw_burst_i;
                    cnt_d   = '0;
                    err_d   = dec_err ? RESP_DECERR : (slv_err ? RESP_SLVERR : RESP_OKAY);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_valid_i) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((w_last_i != final_beat) && (err_q != RESP_DECERR)) err_d = RESP_SLVERR;
                    if (final_beat) state_d = S_RESP;
                end
            end
            S_RESP: if (b_ready_i) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            init_q  <= 1'b0;
            id_q    <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            id_q    <= id_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        len_q   <= len_d;
        size_q  <= size_d;
        burst_q <= burst_d;
    end

    assign aw_ready_o  = (state_q == S_IDLE);
    assign w_ready_o   = (state_q == S_DATA);
    assign b_valid_o   = (state_q == S_RESP);
    assign b_id_o      = id_q;
    assign b_resp_o    = err_q;
    assign mem_we_o    = w_valid_i & w_ready_o & (err_q == RESP_OKAY);
    assign mem_addr_o  = w_ready_o ? IDX_W'((beat_addr - BASE_ADDR) >> OFF_W) : '0;
    assign mem_be_o    = w_ready_o ? (w_strb_i & lane_mask) : '0;
    assign mem_wdata_o = w_data_i;
endmodule

// File: tb/tb_axi_wr_subordinate.sv
// Bench for axi_wr_subordinate: table of bursts with hand-computed beat addresses/enables,
// a write scoreboard fed at drive time, and hand sequences for B stall and reset mid-burst.
module tb_axi_wr_subordinate;
    logic        clk, rst_n;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid, aw_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;

    axi_wr_subordinate dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_id_i(aw_id), .aw_addr_i(aw_addr), .aw_len_i(aw_len), .aw_size_i(aw_size),
        .aw_burst_i(aw_burst), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_last_i(w_last), .w_valid_i(w_valid),
        .w_ready_o(w_ready),
        .b_id_o(b_id), .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_be_o(mem_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] FIX = 2'b00, INC = 2'b01, WRP = 2'b10, RSV = 2'b11;
    localparam int NV = 16;

    typedef struct packed {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [7:0]       strb;
        logic [3:0]       wl;
        logic [3:0]       wr;
        logic [3:0][8:0]  ea;
        logic [3:0][7:0]  eb;
        logic [1:0]       resp;
    } vec_t;

    typedef struct packed {
        logic [8:0]  a;
        logic [7:0]  be;
        logic [63:0] d;
    } wr_t;

    vec_t vecs [NV];
    wr_t  sb [$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write to %0h expected none at %0t", mem_addr, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_e.a));
                chk("wr_be", 64'(mem_be), 64'(mon_e.be));
                chk("wr_data", mem_wdata, mon_e.d);
            end
        end
    end

    function automatic vec_t mk(logic [3:0] id, logic [31:0] a, logic [7:0] l, logic [2:0] s,
                                logic [1:0] b, logic [7:0] st, logic [3:0] wl, logic [3:0] wr,
                                logic [35:0] ea, logic [31:0] eb, logic [1:0] r);
        vec_t v;
        v.id = id; v.addr = a; v.len = l; v.size = s; v.burst = b; v.strb = st;
        v.wl = wl; v.wr = wr; v.ea = ea; v.eb = eb; v.resp = r;
        return v;
    endfunction

    // All driving tasks start and end one time unit after a rising edge.
    task automatic do_aw(logic [3:0] id, logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] b);
        int w = 0;
        aw_id = id; aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_valid = 1'b1;
        @(negedge clk);
        while (!aw_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("aw_accept_wait", 64'(w), 64'd0);
        @(posedge clk);
        #1;
        aw_valid = 1'b0;
    endtask

    task automatic do_w(logic [63:0] d, logic [7:0] st, logic lst, logic exp_wr,
                        logic [8:0] ea, logic [7:0] eb);
        wr_t e;
        w_data = d; w_strb = st; w_last = lst; w_valid = 1'b1;
        if (exp_wr) begin
            e.a = ea; e.be = eb; e.d = d;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("w_ready", 64'(w_ready), 64'd1);
        chk("aw_ready_in_data", 64'(aw_ready), 64'd0);
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic do_b(logic [3:0] id, logic [1:0] r);
        int w = 0;
        b_ready = 1'b1;
        @(negedge clk);
        while (!b_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("b_latency", 64'(w), 64'd0);
        chk("b_id", 64'(b_id), 64'(id));
        chk("b_resp", 64'(b_resp), 64'(r));
        @(posedge clk);
        #1;
        b_ready = 1'b0;
        @(negedge clk);
        chk("aw_ready_after_b", 64'(aw_ready), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_aw_ready"}, 64'(aw_ready), 64'd0);
        chk({tag, "_w_ready"}, 64'(w_ready), 64'd0);
        chk({tag, "_b_valid"}, 64'(b_valid), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_b_id"}, 64'(b_id), 64'd0);
        chk({tag, "_b_resp"}, 64'(b_resp), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("init_hold", 64'(aw_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("aw_ready_after_init", 64'(aw_ready), 64'd1);
        chk("no_b_after_reset", 64'(b_valid), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1; b_ready = 1'b0;

        vecs[0]  = mk(4'h5, 32'h10,   8'd3, 3'd3, INC, 8'hFF, 4'b1000, 4'b1111,
                      {9'd5, 9'd4, 9'd3, 9'd2}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 2'b00);
        vecs[1]  = mk(4'h1, 32'h13,   8'd1, 3'd2, INC, 8'hFF, 4'b0010, 4'b0011,
                      {9'd0, 9'd0, 9'd2, 9'd2}, {8'h00, 8'h00, 8'hF0, 8'h08}, 2'b00);
        vecs[2]  = mk(4'h2, 32'h28,   8'd3, 3'd3, WRP, 8'hFF, 4'b1000, 4'b1111,
                      {9'd4, 9'd7, 9'd6, 9'd5}, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 2'b00);
        vecs[3]  = mk(4'h3, 32'h28,   8'd2, 3'd3, WRP, 8'hFF, 4'b0100, 4'b0000, '0, '0, 2'b10);
        vecs[4]  = mk(4'h4, 32'h20,   8'd2, 3'd3, FIX, 8'hFF, 4'b0100, 4'b0111,
                      {9'd0, 9'd4, 9'd4, 9'd4}, {8'h00, 8'hFF, 8'hFF, 8'hFF}, 2'b00);
        vecs[5]  = mk(4'h6, 32'h1000, 8'd2, 3'd3, FIX, 8'hFF, 4'b0100, 4'b0000, '0, '0, 2'b11);
        vecs[6]  = mk(4'h7, 32'h0,    8'd3, 3'd3, INC, 8'hFF, 4'b0010, 4'b0011,
                      {9'd0, 9'd0, 9'd1, 9'd0}, {8'h00, 8'h00, 8'hFF, 8'hFF}, 2'b10);
        vecs[7]  = mk(4'h8, 32'h0,    8'd0, 3'd4, INC, 8'hFF, 4'b0001, 4'b0000, '0, '0, 2'b10);
        vecs[8]  = mk(4'h9, 32'h0,    8'd0, 3'd3, RSV, 8'hFF, 4'b0001, 4'b0000, '0, '0, 2'b10);
        vecs[9]  = mk(4'hA, 32'hFF8,  8'd0, 3'd3, INC, 8'hFF, 4'b0001, 4'b0001,
                      {9'd0, 9'd0, 9'd0, 9'd511}, {8'h00, 8'h00, 8'h00, 8'hFF}, 2'b00);
        vecs[10] = mk(4'hB, 32'hFF8,  8'd1, 3'd3, INC, 8'hFF, 4'b0010, 4'b0000, '0, '0, 2'b11);
        vecs[11] = mk(4'hC, 32'h1000, 8'd0, 3'd3, INC, 8'hFF, 4'b0000, 4'b0000, '0, '0, 2'b11);
        vecs[12] = mk(4'hD, 32'h2C,   8'd1, 3'd3, WRP, 8'hFF, 4'b0010, 4'b0000, '0, '0, 2'b10);
        vecs[13] = mk(4'hE, 32'h40,   8'd0, 3'd3, INC, 8'h5A, 4'b0001, 4'b0001,
                      {9'd0, 9'd0, 9'd0, 9'd8}, {8'h00, 8'h00, 8'h00, 8'h5A}, 2'b00);
        vecs[14] = mk(4'hF, 32'h42,   8'd1, 3'd1, INC, 8'hFF, 4'b0010, 4'b0011,
                      {9'd0, 9'd0, 9'd8, 9'd8}, {8'h00, 8'h00, 8'h30, 8'h0C}, 2'b00);
        vecs[15] = mk(4'h0, 32'h30,   8'd1, 3'd2, WRP, 8'hFF, 4'b0010, 4'b0011,
                      {9'd0, 9'd0, 9'd6, 9'd6}, {8'h00, 8'h00, 8'hF0, 8'h0F}, 2'b00);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        w_valid = 1'b0;
        release_reset();

        // W offered before any AW must be refused
        w_valid = 1'b1; w_strb = 8'hFF;
        @(negedge clk);
        chk("w_before_aw", 64'(w_ready), 64'd0);
        @(posedge clk);
        #1;
        w_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            do_aw(v.id, v.addr, v.len, v.size, v.burst);
            for (int n = 0; n <= int'(v.len); n++) begin
                do_w({$urandom, $urandom}, v.strb, v.wl[n], v.wr[n], v.ea[n], v.eb[n]);
            end
            do_b(v.id, v.resp);
        end

        // Early w_last, then B held off for five cycles
        do_aw(4'h7, 32'h0, 8'd3, 3'd3, INC);
        do_w({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, 9'd0, 8'hFF);
        do_w({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 9'd1, 8'hFF);
        do_w({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 9'd0, 8'h00);
        do_w({$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 9'd0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_b_valid", 64'(b_valid), 64'd1);
            chk("stall_b_id", 64'(b_id), 64'h7);
            chk("stall_b_resp", 64'(b_resp), 64'h2);
            chk("stall_aw_ready", 64'(aw_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        do_b(4'h7, 2'b10);

        // Reset during beat 2 of an 8-beat burst
        do_aw(4'h3, 32'h100, 8'd7, 3'd3, INC);
        do_w({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, 9'd32, 8'hFF);
        do_w({$urandom, $urandom}, 8'hFF, 1'b0, 1'b1, 9'd33, 8'hFF);
        w_data = {$urandom, $urandom}; w_strb = 8'hFF; w_last = 1'b0; w_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midburst_reset");
        @(negedge clk);
        w_valid = 1'b0;
        @(posedge clk);
        #1;
        release_reset();
        v = vecs[0];
        do_aw(v.id, v.addr, v.len, v.size, v.burst);
        for (int n = 0; n <= int'(v.len); n++) begin
            do_w({$urandom, $urandom}, v.strb, v.wl[n], v.wr[n], v.ea[n], v.eb[n]);
        end
        do_b(v.id, v.resp);

        // Maximum length: 256 beats, counter must not wrap early
        do_aw(4'h9, 32'h0, 8'd255, 3'd3, INC);
        for (int n = 0; n < 256; n++) begin
            do_w({$urandom, $urandom}, 8'hFF, (n == 255), 1'b1, 9'(n), 8'hFF);
        end
        do_b(4'h9, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
